rf_wb_arbiter: RTL and testbench

- Write-side master of the core register file: owns the single RF write port (`rf_wen`/`rf_waddr`/`rf_wdata`) and merges two writeback sources into it.
- Sources: the single-cycle pipeline writeback, and a long-latency unit (load/multiply-divide) buffered through a small FIFO.
- Holds the pending-destination scoreboard that issue logic queries for RAW/WAW stalls.
- Sits between the writeback stage/long-latency units and the register file.

---
 rtl/rf_wb_arbiter.sv | 132 +++++++++++++
 tb/tb_rf_wb_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - register-file write-port arbiter with long-latency FIFO and pending scoreboard
module rf_wb_arbiter #(
  parameter int XLEN          = 32,
  parameter int RF_ADDR_WIDTH = 5,
  parameter int FIFO_DEPTH    = 2,
  parameter int STARVE_LIMIT  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     pipe_wb_valid,
  input  logic [RF_ADDR_WIDTH-1:0] pipe_wb_addr,
  input  logic [XLEN-1:0]          pipe_wb_data,
  input  logic                     lu_valid,
  output logic                     lu_ready,
  input  logic [RF_ADDR_WIDTH-1:0] lu_addr,
  input  logic [XLEN-1:0]          lu_data,
  input  logic                     sb_set_valid,
  input  logic [RF_ADDR_WIDTH-1:0] sb_set_addr,
  input  logic [RF_ADDR_WIDTH-1:0] rs1_addr,
  input  logic [RF_ADDR_WIDTH-1:0] rs2_addr,
  output logic                     rs1_busy,
  output logic                     rs2_busy,
  output logic                     pipe_stall,
  output logic                     rf_wen,
  output logic [RF_ADDR_WIDTH-1:0] rf_waddr,
  output logic [XLEN-1:0]          rf_wdata
);

  localparam int NREGS = 1 << RF_ADDR_WIDTH;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);

  logic [RF_ADDR_WIDTH-1:0] fifo_addr [FIFO_DEPTH];
  logic [XLEN-1:0]          fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]         wr_ptr, rd_ptr;
  logic [CNT_W-1:0]         count, count_next;
  logic [STV_W-1:0]         starve, starve_next;
  logic [NREGS-1:0]         pending, pending_next;
  logic                     pipe_commit, push, pop;
  logic                     commit_wen;
  logic [RF_ADDR_WIDTH-1:0] commit_addr;
  logic [XLEN-1:0]          commit_data;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Ready depends on occupancy only, so a full FIFO never accepts even while popping.
  assign lu_ready    = (count < CNT_W'(FIFO_DEPTH));
  assign push        = lu_valid & lu_ready & (lu_addr != '0);
  assign pipe_commit = pipe_wb_valid & (pipe_wb_addr != '0);
  assign pop         = ~pipe_commit & (count != '0);

  assign rs1_busy = pending[rs1_addr];
  assign rs2_busy = pending[rs2_addr];

  always_comb begin
    count_next = count;
    if (push & ~pop)
      count_next = count + CNT_W'(1);
    else if (pop & ~push)
      count_next = count - CNT_W'(1);
  end

  always_comb begin
    starve_next = starve;
    if (pop || (count == '0))
      starve_next = '0;
    else if (starve != STV_W'(STARVE_LIMIT))
      starve_next = starve + STV_W'(1);
  end

  always_comb begin
    commit_wen  = 1'b0;
    commit_addr = '0;
    commit_data = '0;
    if (pipe_commit) begin
      commit_wen  = 1'b1;
      commit_addr = pipe_wb_addr;
      commit_data = pipe_wb_data;
    end else if (pop) begin
      commit_wen  = 1'b1;
      commit_addr = fifo_addr[rd_ptr];
      commit_data = fifo_data[rd_ptr];
    end
  end

  // Set is applied after clear so a same-edge set wins; x0 is forced clear.
  always_comb begin
    pending_next = pending;
    if (commit_wen)
      pending_next[commit_addr] = 1'b0;
    if (sb_set_valid && (sb_set_addr != '0))
      pending_next[sb_set_addr] = 1'b1;
    pending_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= lu_addr;
      fifo_data[wr_ptr] <= lu_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      starve     <= '0;
      pipe_stall <= 1'b0;
      pending    <= '0;
      rf_wen     <= 1'b0;
      rf_waddr   <= '0;
      rf_wdata   <= '0;
    end else begin
      if (push)
        wr_ptr <= ptr_inc(wr_ptr);
      if (pop)
        rd_ptr <= ptr_inc(rd_ptr);
      count      <= count_next;
      starve     <= starve_next;
      pipe_stall <= (starve_next == STV_W'(STARVE_LIMIT)) && (count_next != '0);
      pending    <= pending_next;
      rf_wen     <= commit_wen;
      rf_waddr   <= commit_addr;
      rf_wdata   <= commit_data;
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb/tb_rf_wb_arbiter.sv - randomized bench for rf_wb_arbiter against a queue-based reference model
module tb_rf_wb_arbiter;

  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pipe_wb_valid = 1'b0;
  logic [4:0]  pipe_wb_addr = '0;
  logic [31:0] pipe_wb_data = '0;
  logic        lu_valid = 1'b0;
  logic        lu_ready;
  logic [4:0]  lu_addr = '0;
  logic [31:0] lu_data = '0;
  logic        sb_set_valid = 1'b0;
  logic [4:0]  sb_set_addr = '0;
  logic [4:0]  rs1_addr = '0;
  logic [4:0]  rs2_addr = '0;
  logic        rs1_busy, rs2_busy, pipe_stall, rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  int total = 0;
  int bad = 0;

  // Reference model state
  logic [36:0] m_q[$];
  bit          m_pend [32];
  bit          m_wen;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  int          m_wait;
  bit          m_stall;

  rf_wb_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .pipe_wb_valid(pipe_wb_valid), .pipe_wb_addr(pipe_wb_addr), .pipe_wb_data(pipe_wb_data),
    .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_addr(lu_addr), .lu_data(lu_data),
    .sb_set_valid(sb_set_valid), .sb_set_addr(sb_set_addr),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .pipe_stall(pipe_stall), .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
    m_wen = 1'b0; m_addr = '0; m_data = '0;
    m_wait = 0; m_stall = 1'b0;
  endtask

  task automatic model_step();
    logic [36:0] e;
    bit had;
    bit rdy;
    bit popd;
    had  = (m_q.size() != 0);
    rdy  = (m_q.size() < DEPTH);
    popd = 1'b0;
    if (pipe_wb_valid && pipe_wb_addr != 0) begin
      m_wen = 1'b1; m_addr = pipe_wb_addr; m_data = pipe_wb_data;
    end else if (had) begin
      e = m_q.pop_front();
      popd = 1'b1;
      m_wen = 1'b1; m_addr = e[36:32]; m_data = e[31:0];
    end else begin
      m_wen = 1'b0; m_addr = '0; m_data = '0;
    end
    if (m_wen) m_pend[m_addr] = 1'b0;
    if (sb_set_valid && sb_set_addr != 0) m_pend[sb_set_addr] = 1'b1;
    if (lu_valid && rdy && lu_addr != 0) m_q.push_back({lu_addr, lu_data});
    if (had && !popd) m_wait = (m_wait < LIMIT) ? m_wait + 1 : LIMIT;
    else m_wait = 0;
    m_stall = (m_wait >= LIMIT) && (m_q.size() != 0);
  endtask

  task automatic check_outputs();
    chk("rf_wen", rf_wen, m_wen);
    chk("rf_waddr", rf_waddr, m_addr);
    chk("rf_wdata", rf_wdata, m_data);
    chk("pipe_stall", pipe_stall, m_stall);
    chk("lu_ready", lu_ready, m_q.size() < DEPTH);
    chk("rs1_busy", rs1_busy, m_pend[rs1_addr]);
    chk("rs2_busy", rs2_busy, m_pend[rs2_addr]);
  endtask

  task automatic cycle(input logic pv, input logic [4:0] pa, input logic [31:0] pd,
                       input logic lv, input logic [4:0] la, input logic [31:0] ld,
                       input logic sv, input logic [4:0] sa,
                       input logic [4:0] r1, input logic [4:0] r2);
    @(negedge clk);
    pipe_wb_valid = pv; pipe_wb_addr = pa; pipe_wb_data = pd;
    lu_valid = lv; lu_addr = la; lu_data = ld;
    sb_set_valid = sv; sb_set_addr = sa;
    rs1_addr = r1; rs2_addr = r2;
    #1;
    check_outputs();
    @(posedge clk);
    model_step();
  endtask

  task automatic idle(input int n, input logic [4:0] r1, input logic [4:0] r2);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, r1, r2);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_wen", rf_wen, 1'b0);
    chk("reset_waddr", rf_waddr, 5'd0);
    chk("reset_wdata", rf_wdata, 32'd0);
    chk("reset_stall", pipe_stall, 1'b0);
    chk("reset_lu_ready", lu_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    // Pipeline write, one-cycle latency
    cycle(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("pipe_wen", rf_wen, 1'b1);
    chk("pipe_waddr", rf_waddr, 5'd5);
    chk("pipe_wdata", rf_wdata, 32'hDEADBEEF);
    idle(2, 0, 0);

    // FIFO fill under pipeline pressure, then drain in order
    cycle(1, 3, 32'h33, 1, 7, 32'h11, 0, 0, 0, 0);
    cycle(1, 3, 32'h33, 1, 8, 32'h22, 0, 0, 0, 0);
    #1;
    chk("fill_lu_ready", lu_ready, 1'b0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("drain1_addr", rf_waddr, 5'd7);
    chk("drain1_data", rf_wdata, 32'h11);
    chk("drain1_ready", lu_ready, 1'b1);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("drain2_addr", rf_waddr, 5'd8);
    chk("drain2_data", rf_wdata, 32'h22);
    idle(1, 0, 0);

    // Starvation: one entry waits behind a continuous pipeline stream
    cycle(1, 2, 32'h2, 1, 12, 32'hC0FFEE, 0, 0, 0, 0);
    for (int i = 0; i < 9; i++) cycle(1, 2, i, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("starve_stall", pipe_stall, 1'b1);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("starve_commit", rf_waddr, 5'd12);
    chk("starve_release", pipe_stall, 1'b0);

    // Scoreboard set, clear on commit, same-edge set wins
    cycle(0, 0, 0, 0, 0, 0, 1, 9, 9, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 9, 0);
    #1;
    chk("sb_busy_set", rs1_busy, 1'b1);
    cycle(1, 9, 32'h99, 0, 0, 0, 0, 0, 9, 0);
    #1;
    chk("sb_busy_clear", rs1_busy, 1'b0);
    cycle(0, 0, 0, 0, 0, 0, 1, 9, 9, 0);
    cycle(1, 9, 32'h98, 0, 0, 0, 1, 9, 9, 0);
    #1;
    chk("sb_set_wins", rs1_busy, 1'b1);
    cycle(1, 9, 32'h97, 0, 0, 0, 0, 0, 9, 0);

    // x0 writes and sets are ignored
    cycle(1, 0, 32'h5555, 1, 0, 32'h6666, 1, 0, 0, 0);
    #1;
    chk("x0_wen", rf_wen, 1'b0);
    chk("x0_ready", lu_ready, 1'b1);
    chk("x0_busy", rs1_busy, 1'b0);
    idle(2, 0, 0);

    // Randomized traffic, sometimes violating the stall request
    for (int i = 0; i < 600; i++) begin
      logic pv;
      pv = ($urandom_range(0, 99) < 60);
      if (m_stall && $urandom_range(0, 99) < 80) pv = 1'b0;
      cycle(pv, 5'($urandom_range(0, 7)), $urandom(),
            ($urandom_range(0, 99) < 50), 5'($urandom_range(0, 7)), $urandom(),
            ($urandom_range(0, 99) < 30), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end
    idle(6, 0, 0);

    // Mid-operation reset with a full FIFO and pending registers
    cycle(1, 3, 32'h3, 1, 10, 32'hA, 1, 4, 4, 6);
    cycle(1, 3, 32'h3, 1, 11, 32'hB, 1, 6, 4, 6);
    cycle(1, 3, 32'h3, 0, 0, 0, 0, 0, 4, 6);
    @(negedge clk);
    pipe_wb_valid = 1'b0; lu_valid = 1'b0; sb_set_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_wen", rf_wen, 1'b0);
    chk("mrst_waddr", rf_waddr, 5'd0);
    chk("mrst_wdata", rf_wdata, 32'd0);
    chk("mrst_ready", lu_ready, 1'b1);
    chk("mrst_busy4", rs1_busy, 1'b0);
    chk("mrst_busy6", rs2_busy, 1'b0);
    chk("mrst_stall", pipe_stall, 1'b0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    idle(5, 4, 6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
